// File: rtl/intxn_pkg.sv
// Shared intersection package: FSM state encoding, clock/timebase defaults and
// a counter-width helper used by the sensor filter and the controller timers.
package intxn_pkg;

  localparam int CLK_HZ_DEF  = 50_000_000;
  localparam int TICK_HZ_DEF = 1000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUALIFY  = 2'd1,
    DETECTED = 2'd2,
    SERVED   = 2'd3
  } state_t;

  // Bits needed to hold 0..max_count; never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 0) ? $clog2(max_count + 1) : 1;
  endfunction

endpackage

// File: rtl/car_sensor_filter_if.sv
// Sensor-side bundle between the road loop, the filter and the intersection
// controller. car_count exists only when CAR_SENSOR_COUNT_EN is defined.
interface car_sensor_filter_if;

  logic       sensor_raw;
  logic       served;
  logic       car_detected;
`ifdef CAR_SENSOR_COUNT_EN
  logic [7:0] car_count;

  modport master (output sensor_raw, served, input  car_detected, car_count);
  modport slave  (input  sensor_raw, served, output car_detected, car_count);
`else
  modport master (output sensor_raw, served, input  car_detected);
  modport slave  (input  sensor_raw, served, output car_detected);
`endif

endinterface

// File: rtl/car_sensor_filter_ms_tick_gen.sv
// Free-running timebase: one-cycle tick every CLK_HZ/TICK_HZ clocks.
// CLK_HZ/TICK_HZ must be an integer of at least 2.
module ms_tick_gen
  import intxn_pkg::*;
#(
  parameter int CLK_HZ  = CLK_HZ_DEF,
  parameter int TICK_HZ = TICK_HZ_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int             TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int             CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST     = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/car_sensor_filter.sv
// Road-loop conditioner: synchronize, debounce on a ms tick, latch the request
// until served, re-arm after release. Optional arrival counter: CAR_SENSOR_COUNT_EN.
module car_sensor_filter
  import intxn_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int TICK_HZ     = TICK_HZ_DEF,
  parameter int DEBOUNCE_MS = 20,
  parameter int RELEASE_MS  = 50
) (
  input  logic                clock,
  input  logic                reset,
  car_sensor_filter_if.slave  bus
);

  localparam int            QW    = cnt_width(DEBOUNCE_MS - 1);
  localparam int            RW    = cnt_width(RELEASE_MS - 1);
  localparam logic [QW-1:0] QLAST = QW'(DEBOUNCE_MS - 1);
  localparam logic [RW-1:0] RLAST = RW'(RELEASE_MS - 1);

  logic          sync_meta;
  logic          sensor_sync;
  logic          tick;
  state_t        state, state_d;
  logic [QW-1:0] qual_cnt, qual_d;
  logic [RW-1:0] rel_cnt, rel_d;

  // NOTE: non-blocking assignment lets both stages shift on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) {sensor_sync, sync_meta} <= 2'b00;
    else       {sensor_sync, sync_meta} <= {sync_meta, bus.sensor_raw};
  end

  ms_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      qual_cnt <= '0;
      rel_cnt  <= '0;
    end else begin
      state    <= state_d;
      qual_cnt <= qual_d;
      rel_cnt  <= rel_d;
    end
  end

  // The sensor level is tested before the tick so a low sample always wins.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d = state;
    qual_d  = qual_cnt;
    rel_d   = rel_cnt;
    case (state)
      IDLE: begin
        if (sensor_sync) begin
          state_d = QUALIFY;
          qual_d  = '0;
        end
      end
      QUALIFY: begin
        if (!sensor_sync) begin
          state_d = IDLE;
          qual_d  = '0;
        end else if (tick) begin
          if (qual_cnt == QLAST) begin
            state_d = DETECTED;
            qual_d  = '0;
          end else begin
            qual_d = qual_cnt + QW'(1);
          end
        end
      end
      DETECTED: begin
        if (bus.served) begin
          state_d = SERVED;
          rel_d   = '0;
        end
      end
      SERVED: begin
        if (sensor_sync) begin
          rel_d = '0;
        end else if (tick) begin
          if (rel_cnt == RLAST) begin
            state_d = IDLE;
            rel_d   = '0;
          end else begin
            rel_d = rel_cnt + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state register, so reset drops it asynchronously.
  assign bus.car_detected = (state == DETECTED);

`ifdef CAR_SENSOR_COUNT_EN
  logic       qualified;
  logic [7:0] car_count;

  assign qualified = (state == QUALIFY) && (state_d == DETECTED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                              car_count <= 8'd0;
    else if (qualified && car_count != 8'hFF) car_count <= car_count + 8'd1;
  end

  assign bus.car_count = car_count;
`endif

endmodule
